// File: rtl/cnn_img_pkg.sv
// Shared constants for the image SRAM sequencer: default geometry and FSM state codes.
package cnn_img_pkg;

    localparam int IMG_W_DEF = 4;
    localparam int IMG_H_DEF = 4;
    localparam int K_DEF     = 3;
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

endpackage

// File: rtl/image_win_addr_gen.sv
// Window/kernel counters for the readout phase and the resulting SRAM address.
// Order is kc fastest, then kr, then wc, then wr; everything wraps to zero after
// the final pixel of the final window.
module image_win_addr_gen #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int K     = 3,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          win_last,
    output logic          img_last
);

    localparam logic [AW-1:0] K_LAST  = AW'(K - 1);
    localparam logic [AW-1:0] WC_LAST = AW'(IMG_W - K);
    localparam logic [AW-1:0] WR_LAST = AW'(IMG_H - K);
    localparam logic [AW-1:0] W_A     = AW'(IMG_W);

    logic [AW-1:0] kc_q, kc_d;
    logic [AW-1:0] kr_q, kr_d;
    logic [AW-1:0] wc_q, wc_d;
    logic [AW-1:0] wr_q, wr_d;
    logic          kc_last_s, kr_last_s, wc_last_s, wr_last_s;

    // Wrap detection and the (row * width + column) address for the current pixel.
    always_comb begin
        kc_last_s = (kc_q == K_LAST);
        kr_last_s = (kr_q == K_LAST);
        wc_last_s = (wc_q == WC_LAST);
        wr_last_s = (wr_q == WR_LAST);
        win_last  = kc_last_s && kr_last_s;
        img_last  = win_last && wc_last_s && wr_last_s;
        addr      = (wr_q + kr_q) * W_A + (wc_q + kc_q);
    end

    // Next-state for the four nested counters; clear wins over advance.
    always_comb begin
        kc_d = kc_q;
        kr_d = kr_q;
        wc_d = wc_q;
        wr_d = wr_q;
        if (clear) begin
            kc_d = '0;
            kr_d = '0;
            wc_d = '0;
            wr_d = '0;
        end else if (advance) begin
            if (!kc_last_s) begin
                kc_d = kc_q + 1'b1;
            end else begin
                kc_d = '0;
                if (!kr_last_s) begin
                    kr_d = kr_q + 1'b1;
                end else begin
                    kr_d = '0;
                    if (!wc_last_s) begin
                        wc_d = wc_q + 1'b1;
                    end else begin
                        wc_d = '0;
                        if (!wr_last_s) begin
                            wr_d = wr_q + 1'b1;
                        end else begin
                            wr_d = '0;
                        end
                    end
                end
            end
        end else begin
            kc_d = kc_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_q <= '0;
            kr_q <= '0;
            wc_q <= '0;
            wr_q <= '0;
        end else begin
            kc_q <= kc_d;
            kr_q <= kr_d;
            wc_q <= wc_d;
            wr_q <= wr_d;
        end
    end

endmodule

// File: rtl/image_sram_ctrl.sv
// Image SRAM sequencer: loads one image from a valid/ready stream, then streams
// it back as KxK stride-1 windows. Writes go straight through to the SRAM in the
// accepting cycle; reads are issued only when the output slot is free or being
// drained, so the SRAM's held read data doubles as the output data register.
module image_sram_ctrl
    import cnn_img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          out_img_last,
    output logic          busy,
    output logic          done,
    output logic          sram_cs,
    output logic          sram_we,
    output logic          sram_rd,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_q
);

    localparam logic [AW-1:0] LAST_BEAT = AW'(IMG_W * IMG_H - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          rd_left_q, rd_left_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          out_img_last_q, out_img_last_d;

    logic          wr_acc_s;
    logic          rd_issue_s;
    logic          out_acc_s;
    logic          gen_clear_s;
    logic [AW-1:0] gen_addr_s;
    logic          gen_win_last_s;
    logic          gen_img_last_s;

    image_win_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .AW    (AW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (gen_clear_s),
        .advance  (rd_issue_s),
        .addr     (gen_addr_s),
        .win_last (gen_win_last_s),
        .img_last (gen_img_last_s)
    );

    // Handshake qualifiers; window counters are held at zero outside readout.
    always_comb begin
        wr_acc_s    = (state_q == ST_LOAD) && in_valid;
        out_acc_s   = out_valid_q && out_ready;
        rd_issue_s  = (state_q == ST_READ) && rd_left_q && (!out_valid_q || out_ready);
        gen_clear_s = (state_q != ST_READ);
    end

    // FSM, write counter and reads-remaining flag.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_left_d = rd_left_q;
        case (state_q)
            ST_IDLE: begin
                wr_cnt_d  = '0;
                rd_left_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (wr_acc_s) begin
                    if (wr_cnt_q == LAST_BEAT) begin
                        wr_cnt_d  = '0;
                        rd_left_d = 1'b1;
                        state_d   = ST_READ;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end
            ST_READ: begin
                if (rd_issue_s && gen_img_last_s) begin
                    rd_left_d = 1'b0;
                end else begin
                    rd_left_d = rd_left_q;
                end
                if (out_acc_s && out_img_last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                wr_cnt_d  = '0;
                rd_left_d = 1'b0;
            end
        endcase
    end

    // Output slot: filled by an issued read, emptied by an accept with no refill.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_img_last_d = out_img_last_q;
        if (rd_issue_s) begin
            out_valid_d    = 1'b1;
            out_last_d     = gen_win_last_s;
            out_img_last_d = gen_img_last_s;
        end else if (out_acc_s) begin
            out_valid_d    = 1'b0;
            out_last_d     = 1'b0;
            out_img_last_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_cnt_q       <= '0;
            rd_left_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_img_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_left_q      <= rd_left_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_img_last_q <= out_img_last_d;
        end
    end

    // SRAM muxing and status outputs.
    always_comb begin
        sram_cs      = wr_acc_s || rd_issue_s;
        sram_we      = wr_acc_s;
        sram_rd      = rd_issue_s;
        sram_din     = in_data;
        if (wr_acc_s) begin
            sram_addr = wr_cnt_q;
        end else if (rd_issue_s) begin
            sram_addr = gen_addr_s;
        end else begin
            sram_addr = '0;
        end
        in_ready     = (state_q == ST_LOAD);
        busy         = (state_q != ST_IDLE);
        out_valid    = out_valid_q;
        out_last     = out_last_q;
        out_img_last = out_img_last_q;
        out_data     = sram_q;
        done         = out_acc_s && out_img_last_q;
    end

endmodule
